// File: rtl/matrix_scan_driver.sv
// matrix_scan_driver: scans a ROWS x COLS framebuffer onto a shift/latch LED chain as PWM bit planes.
// Define FB_DOUBLE_BUFFER_EN to double-buffer the framebuffer, swapping only at frame boundaries.
module matrix_scan_driver #(
    parameter int ROWS       = 8,
    parameter int COLS       = 8,
    parameter int DEPTH_BITS = 2,
    parameter int CLK_DIV    = 1600
) (
    input  logic                                      clk,
    input  logic                                      _rst,
    input  logic                                      en,
    input  logic                                      wr_en,
    input  logic [(ROWS > 1 ? $clog2(ROWS) : 1)-1:0]  wr_row,
    input  logic [(COLS > 1 ? $clog2(COLS) : 1)-1:0]  wr_col,
    input  logic [DEPTH_BITS-1:0]                     wr_data,
    output logic                                      sclk,
    output logic                                      rclk,
    output logic                                      _srclr,
    output logic                                      serial_data,
    output logic                                      frame_done
);
    localparam int W      = ROWS + COLS;
    localparam int PLANES = (1 << DEPTH_BITS) - 1;
    localparam int RW     = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int SCW    = $clog2(2 * W);
    localparam int DW     = CLK_DIV > 0 ? $clog2(CLK_DIV + 1) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_t;

    state_t                state_q;
    logic [DW-1:0]         div_q;
    logic [RW-1:0]         row_q;
    logic [DEPTH_BITS-1:0] plane_q;
    logic [SCW-1:0]        cnt_q;
    logic [W-1:0]          word_q, word_d;
    logic                  sclk_q, rclk_q, sd_q, fd_q, srclr_q;
    logic [DEPTH_BITS-1:0] fb_q [ROWS][COLS];
    logic                  tick, last_row, last_plane, frame_end, wr_ok;

    assign tick       = div_q == DW'(CLK_DIV);
    assign last_row   = row_q == RW'(ROWS - 1);
    assign last_plane = plane_q == DEPTH_BITS'(PLANES - 1);
    assign frame_end  = tick && state_q == LATCH && cnt_q[0] && last_row && last_plane;
    assign wr_ok      = wr_en && 32'(wr_row) < ROWS && 32'(wr_col) < COLS;

    always_comb begin
        word_d = '0;
        word_d[W-1:COLS] = ~(ROWS'(1) << row_q);
        for (int i = 0; i < COLS; i++) word_d[i] = fb_q[row_q][i] > plane_q;
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) div_q <= '0;
        else div_q <= tick ? '0 : div_q + 1'b1;
    end

`ifdef FB_DOUBLE_BUFFER_EN
    logic [DEPTH_BITS-1:0] bk_q [ROWS][COLS];
    logic                  dirty_q;

    // Front only changes at a frame boundary; the back keeps accumulating edits on top of it.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            fb_q    <= '{default: '0};
            bk_q    <= '{default: '0};
            dirty_q <= 1'b0;
        end else begin
            if (wr_ok) bk_q[wr_row][wr_col] <= wr_data;
            if (frame_end && dirty_q) begin
                fb_q    <= bk_q;
                dirty_q <= wr_ok;
            end else if (wr_ok) begin
                dirty_q <= 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) fb_q <= '{default: '0};
        else if (wr_ok) fb_q[wr_row][wr_col] <= wr_data;
    end
`endif

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            plane_q <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            sclk_q  <= 1'b0;
            rclk_q  <= 1'b0;
            sd_q    <= 1'b0;
            fd_q    <= 1'b0;
            srclr_q <= 1'b0;
        end else begin
            fd_q <= frame_end;
            if (tick) begin
                srclr_q <= 1'b1;
                case (state_q)
                    IDLE: if (en) state_q <= LOAD;
                    LOAD: begin
                        word_q  <= word_d;
                        cnt_q   <= '0;
                        state_q <= SHIFT;
                    end
                    SHIFT: begin
                        sclk_q <= cnt_q[0];
                        if (!cnt_q[0]) begin
                            sd_q   <= word_q[W-1];
                            word_q <= word_q << 1;
                        end
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == SCW'(2 * W - 1)) begin
                            cnt_q   <= '0;
                            state_q <= LATCH;
                        end
                    end
                    LATCH: begin
                        sclk_q <= 1'b0;
                        sd_q   <= 1'b0;
                        rclk_q <= !cnt_q[0];
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q[0]) begin
                            cnt_q   <= '0;
                            row_q   <= last_row ? '0 : row_q + 1'b1;
                            if (last_row) plane_q <= last_plane ? '0 : plane_q + 1'b1;
                            state_q <= en ? LOAD : IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign sclk        = sclk_q;
    assign rclk        = rclk_q;
    assign serial_data = sd_q;
    assign frame_done  = fd_q;
    assign _srclr      = srclr_q;
endmodule
